// File: rtl/replay_pkg.sv
// Shared definitions for the replay-buffer sampling controller: FSM state type,
// LFSR width, default seed, feedback tap positions and the LFSR step function.
package replay_pkg;

  localparam int unsigned LfsrW       = 16;
  localparam logic [15:0] LfsrSeedDef = 16'hACE1;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 in a left-shifting register
  localparam int unsigned TapA = 15;
  localparam int unsigned TapB = 13;
  localparam int unsigned TapC = 12;
  localparam int unsigned TapD = 10;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StResp
  } state_e;

  function automatic logic [LfsrW-1:0] lfsr_step(input logic [LfsrW-1:0] s);
    return {s[LfsrW-2:0], s[TapA] ^ s[TapB] ^ s[TapC] ^ s[TapD]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after
// ptr_i (wrapping modulo NREQ).
//  req_i  in  NREQ        request vector
//  ptr_i  in  clog2(NREQ) highest-priority position
//  gnt_o  out NREQ        one-hot grant (zero when no request)
//  id_o   out clog2(NREQ) encoded winner
//  any_o  out 1           at least one request present
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] id_o,
  output logic                    any_o
);

  localparam int unsigned IdW = $clog2(NREQ);

  logic [IdW-1:0] k;

  always_comb begin
    k     = '0;
    id_o  = '0;
    any_o = 1'b0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = IdW'((32'(ptr_i) + 32'(i)) % NREQ);
      if (req_i[k]) begin
        id_o  = k;
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? (NREQ'(1) << id_o) : '0;
  end

endmodule

// File: rtl/replay_sample_ctrl.sv
// Shares one 16-bit LFSR between NREQ requesters that need random slot indices into
// the replay buffer. Round-robin grant, rejection sampling against fill_count, bounded
// retry with fallback to the newest entry, and seed loading while idle.
//  clk, rst      clock, asynchronous active-high reset
//  req/gnt       request levels in, one-cycle one-hot grant out
//  fill_count    valid entries in the buffer (0..2**IDX_W)
//  seed_we/seed  seed load, honoured only while seed_rdy
//  rsp_*         response held from rsp_valid until rsp_ready
module replay_sample_ctrl
  import replay_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned MAX_TRY  = 8,
  parameter logic [15:0] SEED_DEF = LfsrSeedDef
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  input  logic [IDX_W:0]          fill_count,
  input  logic                    seed_we,
  input  logic [15:0]             seed,
  output logic                    seed_rdy,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [IDX_W-1:0]        rsp_idx,
  output logic                    rsp_fallback,
  output logic                    rsp_empty
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned TryW = $clog2(MAX_TRY + 1);

  state_e             state_q, state_d;
  logic [LfsrW-1:0]   lfsr_q, lfsr_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TryW-1:0]    try_cnt_q, try_cnt_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               fb_q, fb_d;
  logic               empty_q, empty_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [IdW-1:0]     arb_id;
  logic               arb_any;
  logic [LfsrW-1:0]   lfsr_nxt;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   idx_fb;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req_i(req),
    .ptr_i(rr_ptr_q),
    .gnt_o(arb_gnt),
    .id_o (arb_id),
    .any_o(arb_any)
  );

  assign lfsr_nxt = lfsr_step(lfsr_q);
  assign cand     = lfsr_nxt[IDX_W-1:0];
  // Only reached with fill_count < 2**IDX_W, so the low bits minus one are exact.
  assign idx_fb   = fill_count[IDX_W-1:0] - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      lfsr_q    <= SEED_DEF;
      rr_ptr_q  <= '0;
      try_cnt_q <= '0;
      id_q      <= '0;
      idx_q     <= '0;
      fb_q      <= 1'b0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      rr_ptr_q  <= rr_ptr_d;
      try_cnt_q <= try_cnt_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      fb_q      <= fb_d;
      empty_q   <= empty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    rr_ptr_d  = rr_ptr_q;
    try_cnt_d = try_cnt_q;
    id_d      = id_q;
    idx_d     = idx_q;
    fb_d      = fb_q;
    empty_d   = empty_q;
    unique case (state_q)
      StIdle: begin
        // A seed load takes the cycle; any pending request is granted afterwards.
        if (seed_we) begin
          lfsr_d = (seed == '0) ? SEED_DEF : seed;
        end else if (arb_any) begin
          rr_ptr_d  = (arb_id == IdW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
          id_d      = arb_id;
          try_cnt_d = '0;
          state_d   = StDraw;
        end
      end
      StDraw: begin
        if (fill_count == '0) begin
          empty_d = 1'b1;
          idx_d   = '0;
          state_d = StResp;
        end else begin
          lfsr_d = lfsr_nxt;
          if ({1'b0, cand} < fill_count) begin
            idx_d   = cand;
            state_d = StResp;
          end else if (32'(try_cnt_q) + 32'd1 == MAX_TRY) begin
            idx_d   = idx_fb;
            fb_d    = 1'b1;
            state_d = StResp;
          end else begin
            try_cnt_d = try_cnt_q + 1'b1;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          id_d    = '0;
          idx_d   = '0;
          fb_d    = 1'b0;
          empty_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt          = (state_q == StIdle && !seed_we) ? arb_gnt : '0;
    seed_rdy     = (state_q == StIdle);
    rsp_valid    = (state_q == StResp);
    rsp_id       = id_q;
    rsp_idx      = idx_q;
    rsp_fallback = fb_q;
    rsp_empty    = empty_q;
  end

endmodule

// File: tb/tb_replay_sample_ctrl.sv
// Directed plus randomized bench for replay_sample_ctrl with a transaction-level model.
module tb_replay_sample_ctrl;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned IDX_W    = 10;
  localparam int unsigned MAX_TRY  = 8;
  localparam int unsigned DEPTH    = 1024;
  localparam logic [15:0] SEED_DEF = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W:0]   fill_count;
  logic             seed_we;
  logic [15:0]      seed;
  logic             seed_rdy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_fallback;
  logic             rsp_empty;

  int checks = 0;
  int errors = 0;

  // Model state: the random source value and the round-robin start position.
  logic [15:0] m_lfsr;
  int unsigned m_ptr;

  always #5 clk = ~clk;

  replay_sample_ctrl #(
    .NREQ    (NREQ),
    .IDX_W   (IDX_W),
    .MAX_TRY (MAX_TRY),
    .SEED_DEF(SEED_DEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .fill_count  (fill_count),
    .seed_we     (seed_we),
    .seed        (seed),
    .seed_rdy    (seed_rdy),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_idx     (rsp_idx),
    .rsp_fallback(rsp_fallback),
    .rsp_empty   (rsp_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  function automatic logic [15:0] rng_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int unsigned pick(input logic [NREQ-1:0] r, input int unsigned ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return 0;
  endfunction

  // Caller is between a negedge and the following posedge with the DUT idle.
  task automatic txn(input logic [NREQ-1:0] pat, input int unsigned f, input bit seed_first,
                     input logic [15:0] sv, input int unsigned rdy_dly, input bit hold,
                     output logic [IDX_W-1:0] got_idx);
    int unsigned win, draws, lat, exp_lat, e_idx, c;
    bit          e_fb, e_empty, found;
    fill_count = 11'(f);
    rsp_ready  = 1'b0;
    req        = pat;
    if (seed_first) begin
      seed_we = 1'b1;
      seed    = sv;
      #1;
      check("seed_blocks_gnt", 32'(gnt), 0);
      check("seed_rdy_idle", 32'(seed_rdy), 1);
      @(negedge clk);
      seed_we = 1'b0;
      m_lfsr  = (sv == 16'd0) ? SEED_DEF : sv;
    end
    #1;
    win = pick(pat, m_ptr);
    check("gnt_onehot", 32'(gnt), 32'(1) << win);
    m_ptr = (win + 1) % NREQ;

    e_fb = 0; e_empty = 0; e_idx = 0; draws = 0; found = 0;
    if (f == 0) begin
      e_empty = 1;
    end else begin
      for (int t = 0; t < MAX_TRY && !found; t++) begin
        m_lfsr = rng_next(m_lfsr);
        draws++;
        c = int'(m_lfsr) % DEPTH;
        if (c < f) begin
          e_idx = c;
          found = 1;
        end
      end
      if (!found) begin
        e_fb  = 1;
        e_idx = f - 1;
      end
    end
    exp_lat = (f == 0) ? 2 : 1 + draws;

    @(negedge clk);
    if (!hold) req = '0;
    #1;
    lat = 1;
    check("gnt_pulse", 32'(gnt), 0);
    while (!rsp_valid && lat < MAX_TRY + 6) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_id", 32'(rsp_id), win);
    check("rsp_idx", 32'(rsp_idx), e_idx);
    check("rsp_fallback", 32'(rsp_fallback), 32'(e_fb));
    check("rsp_empty", 32'(rsp_empty), 32'(e_empty));
    check("seed_rdy_busy", 32'(seed_rdy), 0);
    got_idx = rsp_idx;

    // Hold the response back; a seed write here must be ignored.
    for (int d = 0; d < rdy_dly; d++) begin
      seed_we = 1'b1;
      seed    = 16'($urandom);
      @(negedge clk);
      #1;
      check("rsp_valid_hold", 32'(rsp_valid), 1);
      check("rsp_idx_hold", 32'(rsp_idx), e_idx);
    end
    seed_we   = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("no_gnt_in_resp", 32'(gnt), 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("rsp_valid_clear", 32'(rsp_valid), 0);
    check("flags_clear", 32'({rsp_fallback, rsp_empty}), 0);
    check("seed_rdy_back", 32'(seed_rdy), 1);
  endtask

  initial begin
    logic [IDX_W-1:0] got;
    int unsigned      sel, f;
    rst        = 1'b1;
    req        = '0;
    fill_count = '0;
    seed_we    = 1'b0;
    seed       = '0;
    rsp_ready  = 1'b0;
    m_lfsr     = SEED_DEF;
    m_ptr      = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_seed_rdy", 32'(seed_rdy), 1);
    check("rst_rsp_fields", 32'({rsp_id, rsp_idx, rsp_fallback, rsp_empty}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Empty buffer leaves the random source untouched, so the next draw is the first.
    txn(4'b0001, 0, 0, 16'd0, 0, 0, got);
    txn(4'b0001, DEPTH, 0, 16'd0, 0, 0, got);
    check("first_idx_451", 32'(got), 451);

    // Reset while drawing, then a response held off for five cycles.
    fill_count = 11'd1;
    req        = 4'b0100;
    #1;
    check("pre_rst_gnt", 32'(gnt), 32'(4'b0100));
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_seed_rdy", 32'(seed_rdy), 1);
    @(negedge clk);
    rst    = 1'b0;
    m_lfsr = SEED_DEF;
    m_ptr  = 0;
    txn(4'b1111, DEPTH, 0, 16'd0, 5, 0, got);
    check("post_rst_idx_451", 32'(got), 451);

    // All requesters held: grants rotate and wrap.
    m_ptr = 0;
    rst   = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    m_lfsr = SEED_DEF;
    for (int i = 0; i < 5; i++) txn(4'b1111, DEPTH, 0, 16'd0, 0, 1, got);
    req = '0;

    // Single valid entry: nearly every candidate is rejected.
    txn(4'b0010, 1, 0, 16'd0, 1, 0, got);

    // Zero seed alongside a request.
    txn(4'b0001, DEPTH, 1, 16'd0, 0, 0, got);
    check("zero_seed_idx_451", 32'(got), 451);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       f = 0;
        1:       f = 1;
        2:       f = DEPTH;
        3:       f = $urandom_range(1, DEPTH - 1);
        default: f = $urandom_range(1, 40);
      endcase
      txn(4'($urandom_range(1, 15)), f, ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
    end
    req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
